// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply datapath: sequencer states and
// default result geometry used by both the load controller and the drain.
package mm_pkg;

    localparam int RES_W_DEFAULT     = 16;
    localparam int N_RESULTS_DEFAULT = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_DRAIN,
        ST_CLEAR
    } mm_state_t;

endpackage

// File: rtl/mm_result_bank.sv
// Result bank: N_RESULTS words written one at a time by index, zeroed as a
// whole by a synchronous clear, read through a combinational mux.
module mm_result_bank
    import mm_pkg::*;
#(
    parameter int   RES_W     = RES_W_DEFAULT,
    parameter int   N_RESULTS = N_RESULTS_DEFAULT,
    localparam int  IDX_W     = $clog2(N_RESULTS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [RES_W-1:0] wr_data,
    input  logic             clr,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [RES_W-1:0] rd_data
);

    logic [RES_W-1:0] mem [N_RESULTS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_RESULTS; i++) mem[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < N_RESULTS; i++) mem[i] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < N_RESULTS; i++) begin
                if (wr_idx == IDX_W'(i)) mem[i] <= wr_data;
            end
        end
    end

    // Out-of-range indices read as zero rather than aliasing a real entry.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N_RESULTS; i++) begin
            if (rd_idx == IDX_W'(i)) rd_data = mem[i];
        end
    end

endmodule

// File: rtl/mm_result_drain.sv
// Output-side sequencer: captures a full set of MAC results into the bank,
// streams them out over valid/ready, then clears the bank for the next run.
module mm_result_drain
    import mm_pkg::*;
#(
    parameter int   RES_W     = RES_W_DEFAULT,
    parameter int   N_RESULTS = N_RESULTS_DEFAULT,
    localparam int  IDX_W     = $clog2(N_RESULTS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mac_done,
    input  logic [RES_W-1:0] mac_result,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [RES_W-1:0] out_data,
    output logic             out_last,
    output logic [IDX_W-1:0] final_mux_sel,
    output logic             reg106_ld,
    output logic             output_set,
    output logic             output_clr,
    output logic             mem_clr,
    output logic             busy,
    output logic             overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_RESULTS - 1);

    mm_state_t        state;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            wr_idx  <= '0;
            rd_idx  <= '0;
            overrun <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_CAPTURE;
                        wr_idx  <= '0;
                        rd_idx  <= '0;
                        overrun <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    if (mac_done) begin
                        if (wr_idx == LAST_IDX) begin
                            state  <= ST_DRAIN;
                            wr_idx <= '0;
                            rd_idx <= '0;
                        end else begin
                            wr_idx <= wr_idx + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (mac_done) overrun <= 1'b1;
                    // out_valid is always high here, so out_ready alone accepts.
                    if (out_ready) begin
                        if (rd_idx == LAST_IDX) begin
                            state  <= ST_CLEAR;
                            rd_idx <= '0;
                        end else begin
                            rd_idx <= rd_idx + 1'b1;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (mac_done) overrun <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign reg106_ld     = (state == ST_CAPTURE) && mac_done;
    assign out_valid     = (state == ST_DRAIN);
    assign output_set    = (state == ST_DRAIN);
    assign out_last      = (state == ST_DRAIN) && (rd_idx == LAST_IDX);
    assign output_clr    = (state == ST_CLEAR);
    assign mem_clr       = (state == ST_CLEAR);
    assign busy          = (state != ST_IDLE);
    assign final_mux_sel = rd_idx;

    mm_result_bank #(
        .RES_W     (RES_W),
        .N_RESULTS (N_RESULTS)
    ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (reg106_ld),
        .wr_idx  (wr_idx),
        .wr_data (mac_result),
        .clr     (mem_clr),
        .rd_idx  (final_mux_sel),
        .rd_data (out_data)
    );

endmodule

// File: doc/mm_result_drain.md
# mm_result_drain

Output-side sequencer for the matrix-multiply datapath. It collects `N_RESULTS` finished MAC accumulations into an internal result bank as the compute sequence produces them. It then streams the results out, one word per accepted transfer, over a valid/ready handshake and clears the bank. It sits between the MAC array and the external result port, and completes the load/compute sequence run by the input-side controller.

## Interface
Parameters:
- `RES_W`, 16, width of one MAC result word
- `N_RESULTS`, 9, results per matrix product (3x3)
- `IDX_W`, `$clog2(N_RESULTS)`, index width (derived; not overridable)

Ports:
- `clk`  in  1  single clock; all state updates on posedge
- `reset`  in  1  asynchronous, active-low; low forces reset state immediately
- `start`  in  1  one-cycle pulse from the load controller; arms a new capture
- `mac_done`  in  1  current `mac_result` is a finished accumulation
- `mac_result`  in  RES_W  accumulated MAC value
- `out_ready`  in  1  downstream accepts `out_data` this cycle
- `out_valid`  out  1  `out_data` holds a valid result
- `out_data`  out  RES_W  result word at index `final_mux_sel`
- `out_last`  out  1  high with `out_valid` on index `N_RESULTS-1`
- `final_mux_sel`  out  IDX_W  read index into the bank
- `reg106_ld`  out  1  bank write enable (equals the accepted `mac_done`)
- `output_set`  out  1  high throughout DRAIN
- `output_clr`  out  1  one-cycle pulse in CLEAR
- `mem_clr`  out  1  one-cycle pulse in CLEAR; zeroes the bank
- `busy`  out  1  state is not IDLE
- `overrun`  out  1  sticky error flag; cleared only by reset or `start` in IDLE

## Operation
- States: IDLE, CAPTURE, DRAIN, CLEAR.
- **IDLE**
  - `start` -> CAPTURE; write index `wr_idx`=0; `overrun` cleared.
  - `mac_done` is ignored in IDLE.
- **CAPTURE**
  - Each `mac_done` writes `mac_result` to `bank[wr_idx]` and increments `wr_idx`.
  - The `mac_done` with `wr_idx`=`N_RESULTS-1` writes its value, then moves to DRAIN with `rd_idx`=0.
- **DRAIN**
  - `out_valid`=1 and `out_data`=`bank[rd_idx]`.
  - A transfer is accepted when `out_valid && out_ready`; then `rd_idx`++.
  - An accepted transfer with `rd_idx`=`N_RESULTS-1` moves to CLEAR.
- **CLEAR**: lasts one cycle. `mem_clr`=`output_clr`=1, the bank is zeroed, and the next state is IDLE.
- **Ignored events**
  - `start` outside IDLE is ignored.
  - `mac_done` in DRAIN or CLEAR is ignored and sets `overrun`.
- **Data rules**: `mac_result` is stored unmodified. There is no truncation, saturation or sign handling. The bank is RES_W x N_RESULTS flops.
- **Reset values**:
  - `out_valid`, `out_last`, `reg106_ld`, `output_set`, `output_clr`, `mem_clr`, `busy`, `overrun` = 0.
  - `final_mux_sel`=0, `out_data`=0 (bank zeroed), state IDLE, `wr_idx`=`rd_idx`=0.

## Timing
- `start` is sampled at edge k. CAPTURE and `busy`=1 hold from k.
- `mac_done` is sampled at edge m and the bank write commits at m. `reg106_ld` is a combinational copy of `mac_done` during CAPTURE.
- The final capture at edge m gives `out_valid`=1 with `bank[0]` after edge m, in the same cycle the state reads DRAIN. Capture-to-first-valid latency is 0 extra cycles.
- Valid/ready handshake:
  - `out_valid` must not drop, and `out_data` must not change, until the transfer is accepted.
  - `out_ready` may be high before `out_valid` and is don't-care outside DRAIN.
  - Back-to-back `out_ready`=1 gives one word per cycle, so a full drain takes `N_RESULTS` cycles.
- The final accept at edge d puts the block in CLEAR for cycle d..d+1 and in IDLE from d+1.
  - `start` at d+1 is accepted.
  - `start` during CLEAR is ignored.
- `out_valid`, `out_last`, `output_set` and `final_mux_sel` are decoded from registered state and index only (Moore outputs); they do not depend on `out_ready`.
- Reset asserted mid-operation:
  - All outputs return immediately to their reset values and any partial capture or drain is discarded.
  - After reset deasserts, the block waits for a new `start`.

## Structure
- The shared package `mm_pkg` holds:
  - the state enum (IDLE/CAPTURE/DRAIN/CLEAR)
  - `RES_W`/`N_RESULTS` defaults shared with the load controller
- Natural sub-module: `mm_result_bank`. It contains N_RESULTS x RES_W registers with write enable, write index, synchronous clear, async active-low reset, and a combinational read mux on `final_mux_sel`.
- FSM and counters stay in the top level.

## Test plan
- **Basic drain**: after reset, `start`, then 9 `mac_done` pulses with values 1..9, `out_ready` held 1 -> `out_data` 1..9 on consecutive cycles, `out_last` only with 9, `mem_clr` pulses once, `busy` drops one cycle after the 9th accept.
- **Backpressure**: values 0x0100..0x0108, `out_ready` toggling 1,0,0,1... -> each word held stable while not ready; no word duplicated or skipped.
- **Spurious events**:
  - `mac_done` with 0xFFFF in IDLE -> not captured; the first drained word equals the first post-`start` value.
  - `start` during CAPTURE after 4 writes -> ignored; the sequence continues to 9.
- **Overrun**: extra `mac_done` during DRAIN -> `overrun`=1, drain data unchanged; `start` in IDLE clears `overrun`.
- **Reset mid-drain**: `reset` low after the 3rd accept -> all outputs 0 immediately. After the next run with values 10..18, exactly 10..18 are drained.
- **Back-to-back runs**: `start` at the first IDLE cycle after CLEAR -> the second run drains correctly, and no stale values from the first run (bank reads 0 before being rewritten).
